// File: rtl/gb_instr_issuer.sv
// Buffered instruction issuer: queues host opcodes in a FIFO and issues them one at a
// time to the processor, capturing the probe a fixed latency after each issue strobe.
module gb_instr_issuer #(
    parameter int DEPTH   = 8,
    parameter int LAT     = 2,
    parameter int GAP     = 4,
    parameter int PROBE_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 instruction,
    output logic                       valid,
    input  logic [PROBE_W-1:0]         probe,
    output logic [PROBE_W-1:0]         result,
    output logic                       result_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic [1:0]                 o_dbg_state
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (LAT > GAP) ? LAT : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    // Handshake: a push happens on any rising edge where in_valid && in_ready;
    // in_ready depends only on the registered count, so a pop never frees a slot
    // for a push on the same edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic [7:0]         r_instruction;
    logic               r_valid;
    logic [PROBE_W-1:0] r_result;
    logic               r_result_valid;

    state_t             w_next_state;
    logic [TW-1:0]      w_next_timer;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;

    assign in_ready     = (r_count != (AW+1)'(DEPTH));
    assign w_push       = in_valid && in_ready;
    assign instruction  = r_instruction;
    assign valid        = r_valid;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign count        = r_count;
    assign busy         = (r_state != S_IDLE) || (r_count != '0);
    assign o_dbg_state  = r_state;

    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
                w_next_timer = TW'(LAT);
            end
            S_WAIT: begin
                if (r_timer == TW'(1)) begin
                    w_capture = 1'b1;
                    if (GAP > 0) begin
                        w_next_state = S_GAP;
                        w_next_timer = TW'(GAP);
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_timer = r_timer - TW'(1);
                end
            end
            S_GAP: begin
                if (r_timer == TW'(1)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_timer = r_timer - TW'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_instruction  <= 8'h00;
            r_valid        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_timer        <= w_next_timer;
            r_valid        <= w_pop;
            r_instruction  <= w_pop ? r_mem[r_rd_ptr] : 8'h00;
            r_result_valid <= w_capture;
            if (w_capture) begin
                r_result <= probe;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Directed and random stimulus for gb_instr_issuer, checked every cycle against a
// timing model built from the issue-period and latency rules.
module tb_gb_instr_issuer;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam int GAP   = 4;
    localparam int P     = LAT + GAP + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_instr = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] instruction;
    logic       valid;
    logic [7:0] probe = 8'h00;
    logic [7:0] result;
    logic       result_valid;
    logic [3:0] count;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a plain queue of accepted opcodes plus issue timestamps.
    logic [7:0] exp_q[$];
    int         m_n       = 0;
    int         m_last    = -1000;
    logic [7:0] m_last_op = 8'h00;
    logic [7:0] m_result  = 8'h00;

    gb_instr_issuer #(.DEPTH(DEPTH), .LAT(LAT), .GAP(GAP), .PROBE_W(8)) dut (
        .clock(clock), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .instruction(instruction), .valid(valid), .probe(probe),
        .result(result), .result_valid(result_valid), .count(count), .busy(busy),
        .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, m_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last   = -1000;
        m_result = 8'h00;
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle, advance model.
    task automatic step(input logic rst_lvl, input logic v, input logic [7:0] d, input logic [7:0] p);
        logic exp_valid;
        logic rdy;
        reset    = rst_lvl;
        in_valid = v;
        in_instr = d;
        probe    = p;
        if (!rst_lvl) model_reset();
        @(negedge clock);
        exp_valid = (m_n == m_last);
        check("in_ready", in_ready, exp_q.size() != DEPTH);
        check("count", count, exp_q.size());
        check("valid", valid, exp_valid);
        check("instruction", instruction, exp_valid ? m_last_op : 8'h00);
        check("result_valid", result_valid, m_n == m_last + LAT + 1);
        check("result", result, m_result);
        check("busy", busy, (exp_q.size() != 0) || (m_n >= m_last && m_n <= m_last + P - 2));
        @(posedge clock);
        if (reset) begin
            rdy = (exp_q.size() != DEPTH);
            if (m_n == m_last + LAT) m_result = p;
            if (exp_q.size() > 0 && m_n + 1 >= m_last + P) begin
                m_last    = m_n + 1;
                m_last_op = exp_q.pop_front();
            end
            if (v && rdy) exp_q.push_back(d);
        end
        m_n++;
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 8'h00, 8'($urandom));
    endtask

    initial begin
        int t0;
        logic found;
        @(posedge clock);
        #1;
        // Reset held with in_valid asserted: nothing may be accepted.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hFF, 8'h33);
        idle(5);

        // Single opcode with a constant probe.
        step(1'b1, 1'b1, 8'h8C, 8'h5A);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, 8'h5A);

        // Three back-to-back opcodes.
        step(1'b1, 1'b1, 8'h80, 8'($urandom));
        step(1'b1, 1'b1, 8'h81, 8'($urandom));
        step(1'b1, 1'b1, 8'h82, 8'($urandom));
        idle(30);

        // Saturate the FIFO; pops while full must not admit a push on the same edge.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(i), 8'($urandom));
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 8'($urandom));
        idle(90);
        check("drained_fifo", exp_q.size(), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'b1, $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
        idle(100);

        // Reset in the WAIT cycle after the first of three queued opcodes.
        t0 = m_n;
        step(1'b1, 1'b1, 8'hA1, 8'($urandom));
        step(1'b1, 1'b1, 8'hA2, 8'($urandom));
        step(1'b1, 1'b1, 8'hA3, 8'($urandom));
        found = (m_last >= t0) && (m_n > m_last);
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b1, 1'b0, 8'h00, 8'($urandom));
            found = (m_last >= t0) && (m_n > m_last);
        end
        check("t6_issue_seen", found, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'($urandom));
        step(1'b0, 1'b0, 8'h00, 8'($urandom));
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gb_instr_issuer.md
Name: gb_instr_issuer

Overview:
- Buffered instruction issuer that drives the gbprocessor instruction/valid input.
- Accepts 8-bit opcodes from a host on a valid/ready stream into a small FIFO.
- Issues one opcode at a time as a single-cycle valid pulse, then waits a fixed latency and captures the processor probe as the result for that opcode.
- Sits between a host or stimulus source and the processor, in place of hand-driven instruction/valid stimuli.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
LAT, 2, cycles after the valid pulse before probe is sampled; >= 1
GAP, 4, idle cycles enforced after the result; >= 0
PROBE_W, 8, probe/result width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
in_instr  in  8  host opcode
in_valid  in  1  host opcode valid
in_ready  out  1  FIFO can accept; combinational, = (count != DEPTH)
instruction  out  8  opcode to processor
valid  out  1  one-cycle issue strobe to processor
probe  in  PROBE_W  processor probe
result  out  PROBE_W  probe captured for the last issued opcode
result_valid  out  1  one-cycle strobe, result updated
count  out  $clog2(DEPTH)+1  FIFO occupancy
busy  out  1  (state != IDLE) || (count != 0)

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - instruction=8'h00, valid=0, result=0, result_valid=0, count=0, pointers=0, state=IDLE.
  - Reset asserted mid-operation drops valid immediately and discards FIFO contents.
  - Pushes are ignored while reset is asserted.
  - in_ready=1 after reset.
- Push: occurs on an edge where in_valid && in_ready.
  - Full FIFO: in_ready=0, in_valid is ignored, no overwrite.
  - Pop on the same edge does not enable a push.
- Pop: occurs only on the IDLE->ISSUE transition, based on the registered count.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- FSM (registered outputs):
  - IDLE: valid=0, instruction=0. If count>0: pop head and go to ISSUE.
  - ISSUE: exactly 1 cycle. valid=1, instruction=popped opcode. Next state is WAIT with wait counter=LAT.
  - WAIT: valid=0, instruction=0. Decrement once per cycle. On the edge ending the LAT-th WAIT cycle: result<=probe, and result_valid=1 for the next cycle.
    - Next state: GAP if GAP>0, else IDLE.
  - GAP: GAP cycles, valid=0, then IDLE.
- Timing, with valid high in cycle c:
  - Probe is sampled at the end of cycle c+LAT.
  - result_valid is high in cycle c+LAT+1.
  - The earliest next valid is in cycle c+LAT+GAP+2.
  - Issue period is LAT+GAP+2 cycles (8 with defaults).
- Push into an empty FIFO while IDLE at edge e: valid is high in the cycle after edge e+1 (2-cycle latency).
- result holds its value until the next capture. result_valid is never high for two consecutive cycles.
- Width rules: count saturates at DEPTH by construction. in_instr passes through unmodified.

Test Plan:
1. Hold reset=0 for 5 cycles with in_valid=1 and in_instr=8'hFF -> valid=0, instruction=8'h00, count=0, result=0, result_valid=0, busy=0, in_ready=1. After release, no issue occurs.
2. Idle, push single 8'h8C, probe held at 8'h5A -> valid=1 for exactly one cycle with instruction=8'h8C, 2 cycles after the push edge. result=8'h5A with result_valid pulse 3 cycles after the valid cycle. Then busy=0.
3. Push 8'h80, 8'h81, 8'h82 on consecutive cycles -> three valid pulses, 8 cycles apart, in order 80/81/82. result_valid follows each by 3 cycles. count never exceeds 2.
4. Hold in_valid=1 for 20 cycles with incrementing opcodes 8'h00.. and log accepted ones -> count reaches 8, in_ready=0 while count=8. Every accepted opcode is issued exactly once, in order. No accepted opcode is dropped and none is issued that was not accepted.
5. Full FIFO (count=8) when the FSM pops, with in_valid=1 -> no push on that edge (in_ready was 0), count goes to 7. A push on the following edge succeeds and count returns to 8.
6. Three opcodes queued, assert reset in the WAIT cycle after the first valid -> valid=0 and count=0 immediately, no result_valid pulse. After release with in_valid=0, valid stays 0 for 20 cycles.
